// File: rtl/golden_nonce_reporter_pkg.sv
// Shared miner constants: UART framing, nonce layout and transmitter FSM encodings.
// Also intended for the work-loader UART RX.
package golden_nonce_reporter_pkg;

    localparam logic UART_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    localparam int unsigned BYTES_PER_NONCE = 4;
    localparam int unsigned BITS_PER_BYTE   = 8;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

    // Nonces go out big-endian: index 0 is bits [31:24].
    function automatic logic [7:0] nonce_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/golden_nonce_reporter_uart_tx.sv
// 8N1 UART byte transmitter: START/DATA/STOP with a per-bit baud counter.
// A new byte accepted on the final STOP cycle follows with no idle gap.
module uart_tx_byte
    import golden_nonce_reporter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       txd_o,
    output logic       idle_o,
    output logic       done_o
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       byte_q, byte_d;
    logic             txd_q, txd_d;
    logic             baud_last;
    logic             accept;

    assign baud_last = (baud_q == BaudLast);
    assign done_o    = (state_q == ST_STOP) && baud_last;
    assign idle_o    = (state_q == ST_IDLE);
    assign accept    = start_i && (idle_o || done_o);
    assign txd_o     = txd_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BaudW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        txd_d   = txd_q;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                txd_d  = UART_IDLE;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = byte_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
                        state_d = ST_STOP;
                        txd_d   = UART_IDLE;
                    end else begin
                        // Shift so the next data bit is always at byte_q[1].
                        bit_d  = bit_q + 3'd1;
                        txd_d  = byte_q[1];
                        byte_d = {1'b0, byte_q[7:1]};
                    end
                end
            end
            default: begin
                if (baud_last) begin
                    state_d = ST_IDLE;
                    baud_d  = '0;
                end
            end
        endcase

        if (accept) begin
            state_d = ST_START;
            baud_d  = '0;
            bit_d   = '0;
            byte_d  = byte_i;
            txd_d   = START_BIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            txd_q   <= UART_IDLE;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/golden_nonce_reporter.sv
// Captures golden nonces into a small FIFO and sends each one over UART as four 8N1 bytes.
// Overflow is sticky until reset.
module golden_nonce_reporter
    import golden_nonce_reporter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        hash_clk,
    input  logic        reset,
    input  logic        nonce_valid,
    input  logic [31:0] golden_nonce,
    output logic        uart_txd,
    output logic        busy,
    output logic        fifo_overflow
);

    localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PtrW  = FIFO_DEPTH_LOG2;
    localparam int unsigned CntW  = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [1:0]      LastByte = 2'(BYTES_PER_NONCE - 1);

    logic [31:0]     mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      byte_idx_q, byte_idx_d;

    logic       push, pop;
    logic       tx_start, tx_idle, tx_done, tx_txd;
    logic [7:0] tx_byte;

    // Pop only when the transmitter is fully idle, so a new nonce never cuts into a frame.
    assign pop  = tx_idle && (count_q != '0);
    assign push = nonce_valid && ((count_q != DepthCnt) || pop);

    always_comb begin
        wptr_d     = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + PtrW'(1) : rptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        overflow_d = overflow_q | (nonce_valid & ~push);

        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        tx_start   = 1'b0;
        tx_byte    = nonce_byte(word_q, byte_idx_q + 2'd1);
        if (pop) begin
            word_d     = mem_q[rptr_q];
            byte_idx_d = 2'd0;
            tx_start   = 1'b1;
            tx_byte    = nonce_byte(mem_q[rptr_q], 2'd0);
        end else if (tx_done && (byte_idx_q != LastByte)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_start   = 1'b1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem_q[wptr_q] <= golden_nonce;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            word_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i  (hash_clk),
        .rst_i  (reset),
        .start_i(tx_start),
        .byte_i (tx_byte),
        .txd_o  (tx_txd),
        .idle_o (tx_idle),
        .done_o (tx_done)
    );

    assign uart_txd      = tx_txd;
    assign busy          = (count_q != '0) || !tx_idle;
    assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench: a fast instance (4 clocks/bit) with a UART byte monitor, and a
// 434 clocks/bit instance checked cycle-by-cycle against the expected line pattern.
module tb_golden_nonce_reporter;

    logic        clk = 1'b0;
    logic        reset, nv;
    logic [31:0] gn;
    logic        txd, busy, ovf;
    logic        rst2, nv2;
    logic [31:0] gn2;
    logic        txd2, busy2, ovf2;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int frame_err = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    golden_nonce_reporter #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .hash_clk     (clk),
        .reset        (reset),
        .nonce_valid  (nv),
        .golden_nonce (gn),
        .uart_txd     (txd),
        .busy         (busy),
        .fifo_overflow(ovf)
    );

    golden_nonce_reporter #(
        .CLKS_PER_BIT(434),
        .FIFO_DEPTH_LOG2(2)
    ) dut_slow (
        .hash_clk     (clk),
        .reset        (rst2),
        .nonce_valid  (nv2),
        .golden_nonce (gn2),
        .uart_txd     (txd2),
        .busy         (busy2),
        .fifo_overflow(ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic get_word(output logic [31:0] w, output int t0);
        w  = 'x;
        t0 = -1;
        if (rx_q.size() >= 4) begin
            t0 = rx_t[0];
            for (int i = 0; i < 4; i++) begin
                w = {w[23:0], rx_q.pop_front()};
                void'(rx_t.pop_front());
            end
        end
    endtask

    // Byte monitor for the fast instance: every bit must hold for exactly 4 cycles.
    initial begin : uart_mon
        logic [39:0] smp;
        logic [7:0]  b;
        logic        abort;
        int          t0;
        forever begin
            @(posedge clk);
            #1;
            if (txd === 1'b0 && reset === 1'b0) begin
                t0     = cyc;
                smp    = '0;
                smp[0] = txd;
                abort  = 1'b0;
                for (int j = 1; j < 40; j++) begin
                    @(posedge clk);
                    #1;
                    smp[j] = txd;
                    if (reset !== 1'b0) abort = 1'b1;
                end
                if (!abort) begin
                    for (int bi = 0; bi < 10; bi++)
                        for (int k = 1; k < 4; k++)
                            if (smp[4*bi+k] !== smp[4*bi]) frame_err++;
                    if (smp[0] !== 1'b0 || smp[36] !== 1'b1) frame_err++;
                    for (int i = 0; i < 8; i++) b[i] = smp[4 + 4*i];
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin : main
        int          k;
        int          t0;
        int          rel;
        int          pos;
        int          line_bad;
        int          busy_bad;
        int          maxb;
        logic        exp_line;
        logic [7:0]  a5;
        logic [31:0] w;

        reset = 1'b1; nv = 1'b0; gn = '0;
        rst2  = 1'b1; nv2 = 1'b0; gn2 = '0;
        repeat (3) tick();
        reset = 1'b0;
        rst2  = 1'b0;

        check("reset_txd", txd, 1);
        check("reset_busy", busy, 0);
        check("reset_ovf", ovf, 0);
        check("reset_txd_slow", txd2, 1);

        // 1: single nonce
        k = cyc;
        nv = 1'b1; gn = 32'hDEADBEEF;
        tick();
        nv = 1'b0;
        check("t1_busy_after_push", busy, 1);
        check("t1_line_before_start", txd, 1);
        tick();
        check("t1_start_bit", txd, 0);
        tick_until(k + 161);
        check("t1_busy_last_stop", busy, 1);
        tick();
        check("t1_busy_fall", busy, 0);
        check("t1_line_idle", txd, 1);
        check("t1_ovf", ovf, 0);
        get_word(w, t0);
        check("t1_word", w, 32'hDEADBEEF);
        check("t1_start_time", t0, k + 2);
        check("t1_framing", frame_err, 0);

        // 2: six back-to-back pulses, sixth dropped
        do_reset();
        k = cyc;
        nv = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            gn = 32'(i);
            if (i == 6) check("t2_ovf_before_drop", ovf, 0);
            tick();
        end
        nv = 1'b0;
        check("t2_ovf_set", ovf, 1);
        tick_until(k + 805);
        check("t2_busy_last", busy, 1);
        tick();
        check("t2_busy_fall", busy, 0);
        check("t2_ovf_sticky", ovf, 1);
        for (int i = 1; i <= 5; i++) begin
            get_word(w, t0);
            check($sformatf("t2_word%0d", i), w, 32'(i));
            check($sformatf("t2_time%0d", i), t0, k + 2 + 161*(i-1));
        end
        check("t2_no_sixth", rx_q.size(), 0);

        // 3: push on the pop cycle with FIFO full
        do_reset();
        k = cyc;
        nv = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            gn = 32'hA0000000 + 32'(i);
            tick();
        end
        nv = 1'b0;
        tick_until(k + 162);
        check("t3_count_full", 32'(dut.count_q), 4);
        nv = 1'b1; gn = 32'hF00DCAFE;
        tick();
        nv = 1'b0;
        check("t3_count_kept", 32'(dut.count_q), 4);
        check("t3_no_ovf", ovf, 0);
        tick_until(k + 967);
        check("t3_busy_fall", busy, 0);
        check("t3_ovf_end", ovf, 0);
        for (int i = 1; i <= 5; i++) begin
            get_word(w, t0);
            check($sformatf("t3_word%0d", i), w, 32'hA0000000 + 32'(i));
        end
        get_word(w, t0);
        check("t3_word6", w, 32'hF00DCAFE);

        // 4: reset in the data bits of byte 2 with pending nonces and overflow set
        do_reset();
        k = cyc;
        nv = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            gn = (i == 1) ? 32'h11223344 : 32'h55667700 + 32'(i);
            tick();
        end
        nv = 1'b0;
        tick_until(k + 96);
        check("t4_ovf_before_reset", ovf, 1);
        reset = 1'b1;
        tick();
        check("t4_rst_txd", txd, 1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_ovf", ovf, 0);
        tick();
        reset = 1'b0;
        tick_until(k + 300);
        check("t4_pending_gone", busy, 0);
        check("t4_line_idle", txd, 1);
        check("t4_bytes_before_reset", rx_q.size(), 2);
        rx_q.delete();
        rx_t.delete();
        k = cyc;
        nv = 1'b1; gn = 32'h00000080;
        tick();
        nv = 1'b0;
        tick_until(k + 162);
        check("t4_busy_fall", busy, 0);
        get_word(w, t0);
        check("t4_word", w, 32'h00000080);
        check("t4_time", t0, k + 2);

        // 5: two nonces 500 cycles apart
        do_reset();
        k = cyc;
        nv = 1'b1; gn = 32'h12345678;
        tick();
        nv = 1'b0;
        tick_until(k + 500);
        nv = 1'b1; gn = 32'h9ABCDEF0;
        tick();
        nv = 1'b0;
        tick_until(k + 662);
        check("t5_busy_fall", busy, 0);
        check("t5_byte_count", rx_q.size(), 8);
        get_word(w, t0);
        check("t5_word1", w, 32'h12345678);
        check("t5_time1", t0, k + 2);
        get_word(w, t0);
        check("t5_word2", w, 32'h9ABCDEF0);
        check("t5_time2", t0, k + 502);
        check("t5_framing", frame_err, 0);

        // 6: 434 clocks/bit, line compared against the expected pattern every cycle
        a5 = 8'hA5;
        line_bad = 0;
        busy_bad = 0;
        maxb = 0;
        k = cyc;
        nv2 = 1'b1; gn2 = 32'hA5A5A5A5;
        tick();
        nv2 = 1'b0;
        while (cyc <= k + 2 + 17362) begin
            rel = cyc - (k + 2);
            if (rel < 0 || rel >= 17360) begin
                exp_line = 1'b1;
            end else begin
                pos = (rel / 434) % 10;
                if (pos == 0)      exp_line = 1'b0;
                else if (pos == 9) exp_line = 1'b1;
                else               exp_line = a5[pos-1];
            end
            if (txd2 !== exp_line) line_bad++;
            if (busy2 !== (rel < 17360)) busy_bad++;
            if (int'(dut_slow.u_tx.baud_q) > maxb) maxb = int'(dut_slow.u_tx.baud_q);
            tick();
        end
        check("t6_line_pattern", line_bad, 0);
        check("t6_busy_window", busy_bad, 0);
        check("t6_baud_max", maxb, 433);
        check("t6_ovf", ovf2, 0);

        check("final_framing", frame_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
